// File: rtl/config_uart_tx.sv
// Buffered 8N1 UART transmitter feeding the fabric configuration Rx line.
// Bytes enter a small FIFO over valid/ready and are sent LSB-first, back-to-back when queued.
module config_uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [7:0]                   data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic                         Tx,
  output logic                         busy_o,
  output logic [$clog2(FIFO_DEPTH):0]  level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ZERO = CW'(0);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(0);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic w_full;
  logic w_nonempty;
  logic w_push;
  logic w_pop;
  logic w_baud_end;

  // Fullness comes from the registered count only, so a same-cycle pop never frees a slot
  assign w_full     = (r_count == CNT_FULL);
  assign w_nonempty = (r_count != CNT_ZERO);
  assign w_push     = valid_i & ~w_full;
  assign w_baud_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = w_nonempty;
      S_STOP:  w_pop = w_nonempty & w_baud_end;
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_count  <= CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame sequencer; the stop bit can hand over straight to the next start bit
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= BAUD_ZERO;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_baud  <= BAUD_ZERO;
            r_bit   <= 3'd0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end else begin
            r_tx    <= 1'b1;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= BAUD_ZERO;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud  <= r_baud + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= BAUD_ZERO;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= BAUD_ZERO;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_bit   <= 3'd0;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= BAUD_ZERO;
          r_bit   <= 3'd0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign Tx      = r_tx;
  assign ready_o = ~w_full;
  assign busy_o  = (r_state != S_IDLE) | w_nonempty;
  assign level_o = r_count;

endmodule

// File: doc/config_uart_tx.md
Name: config_uart_tx

Overview:
- Buffered 8N1 UART transmitter: the sending end of the fabric's serial configuration port, driving the eFPGA `Rx` input.
- Sits in the user-project wrapper beside the fabric top.
- Accepts bitstream bytes from an on-chip source (Wishbone or LA bridge) over a valid/ready handshake and serialises them LSB-first on `Tx`.
- Lets the management core load the fabric without an external host.

Parameters:
- CLKS_PER_BIT, 217, CLK cycles per UART bit; legal range ≥ 2.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, ≥ 2.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  8  byte to transmit.
- valid_i  input  1  data_i valid.
- ready_o  output  1  FIFO can accept a byte this cycle.
- Tx  output  1  serial line to fabric Rx; idles high.
- busy_o  output  1  a frame is in progress or the FIFO is non-empty.
- level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO emptied, FSM to IDLE, bit and baud counters cleared.
  - Outputs during reset: Tx=1, ready_o=1, busy_o=0, level_o=0.
  - Reset mid-frame aborts the frame; Tx returns high immediately, with no partial stop bit.
- Push handshake: a byte is pushed on a rising edge where valid_i && ready_o.
  - ready_o = !full, derived from the registered count only.
  - A full FIFO refuses the push even if a pop happens the same cycle.
- Simultaneous push and pop when not full: level unchanged; data ordering preserved (FIFO order).
- valid_i with ready_o=0: ignored. The source must hold the byte until accepted.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: Tx=1. If FIFO non-empty, pop the head into the shift register, clear counters, go to START.
  - START: Tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: Tx = shift[0]. Every CLKS_PER_BIT cycles, shift right; after 8 bits go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps; bit counter runs 0..7.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: byte pushed into an empty FIFO with FSM in IDLE at edge N → popped at edge N+1; Tx low from edge N+1.
- Tx is a registered output with no combinational path from inputs.
- busy_o = (state != IDLE) || (level != 0); registered or combinational from registered state.
- level_o counts bytes waiting, excluding the byte in the shift register. It wraps neither way: push is blocked when full, pop happens only when non-empty.
- Inputs arriving during reset are ignored.

Test Plan:
- CLKS_PER_BIT=4: push 0xA5 from idle → Tx low at edge N+1 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles; busy_o falls after the 40th cycle.
- Push 0x00 then 0xFF back-to-back → second start bit immediately follows the first stop bit; total 80 cycles with no idle gap; level_o goes 1→0 at the pops.
- FIFO_DEPTH=4: hold valid_i during a frame with 5 bytes queued → ready_o=0 at level 4; a push attempted on the pop cycle is refused; all 5 bytes emerge in order.
- Assert reset in the middle of the DATA bit 3 of 0x3C with 2 bytes queued → Tx=1 immediately, level_o=0, busy_o=0; after release, Tx stays high with no frame.
- Random 64-byte stream with random valid_i gaps, checked by a behavioural UART receiver model → bytes match in order, none lost or duplicated.
- CLKS_PER_BIT=2 corner: push 0x81 → exact 20-cycle frame and correct bit timing.
